// File: rtl/ysyx_22041211_fetch_unit.sv
// ysyx_22041211_fetch_unit
// Instruction fetch unit. It turns one fetch request per PC into a single-beat
// AXI-lite style read (AR then R channel). The returned word goes to decode
// over a valid/ready handshake. After decode takes the word, a one-cycle
// fetch_done_o pulse qualifies the PC register update. Only one request is
// in flight at a time.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   pc_i, fetch_req_i    PC to fetch and request strobe (taken only when idle)
//   araddr_o, arvalid_o, arready_i                read-address channel
//   rdata_i, rresp_i, rvalid_i, rready_o          read-data channel
//   inst_o, inst_valid_o, inst_ready_i            instruction to decode
//   fetch_done_o         one-cycle pulse after decode accepts the instruction
//   busy_o               high whenever the unit is not idle
//   err_o                fault flag that goes with the current inst_o
//
// Optional feature: YSYX_22041211_FETCH_MISALIGN_CHK_EN. When defined, a
// request with pc_i[1:0] != 0 skips the bus and returns a faulted NOP.

module ysyx_22041211_fetch_unit #(
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic                fetch_req_i,
    output logic [ADDR_LEN-1:0] araddr_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [DATA_LEN-1:0] rdata_i,
    input  logic [1:0]          rresp_i,
    input  logic                rvalid_i,
    output logic                rready_o,
    output logic [DATA_LEN-1:0] inst_o,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic                fetch_done_o,
    output logic                busy_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    // addi x0, x0, 0; stands in for the word on any fetch fault
    localparam logic [DATA_LEN-1:0] NOP_INST  = DATA_LEN'(32'h0000_0013);
    localparam logic [1:0]          RESP_OKAY = 2'b00;

    state_t state;

    // Fetch FSM; every output is a register updated alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            araddr_o     <= '0;
            arvalid_o    <= 1'b0;
            rready_o     <= 1'b0;
            inst_o       <= '0;
            inst_valid_o <= 1'b0;
            fetch_done_o <= 1'b0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            // The completion pulse lasts for exactly one cycle
            fetch_done_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (fetch_req_i) begin
                        busy_o <= 1'b1;
`ifdef YSYX_22041211_FETCH_MISALIGN_CHK_EN
                        // A misaligned PC never reaches the bus
                        if (pc_i[1:0] != 2'b00) begin
                            inst_o       <= NOP_INST;
                            err_o        <= 1'b1;
                            inst_valid_o <= 1'b1;
                            state        <= HOLD;
                        end else
`endif
                        begin
                            araddr_o  <= pc_i;
                            arvalid_o <= 1'b1;
                            state     <= ADDR;
                        end
                    end
                end

                ADDR: begin
                    // araddr_o is not written here, so it stays stable under arvalid_o
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        state     <= DATA;
                    end
                end

                DATA: begin
                    if (rvalid_i) begin
                        rready_o     <= 1'b0;
                        inst_valid_o <= 1'b1;
                        err_o        <= (rresp_i != RESP_OKAY);
                        inst_o       <= (rresp_i != RESP_OKAY) ? NOP_INST : rdata_i;
                        state        <= HOLD;
                    end
                end

                HOLD: begin
                    // inst_o / err_o are left untouched until the next capture
                    if (inst_ready_i) begin
                        inst_valid_o <= 1'b0;
                        busy_o       <= 1'b0;
                        fetch_done_o <= 1'b1;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
